// File: rtl/line_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_window_buffer
// Purpose  : Streaming line buffer that builds a P_WIN x P_WIN pixel window
//            from a raster pixel stream. It qualifies windows with out_valid
//            and reports the centre coordinates of each qualified window.
// Option   : `LINE_WINDOW_EDGE_MASK_EN emits top/left border centres and
//            zeroes the taps that fall outside the frame.
// Revision : 1.0 - initial release
// ============================================================================
module line_window_buffer #(
    parameter int P_PIXEL_W     = 24,
    parameter int P_LINE_LEN    = 640,
    parameter int P_FRAME_LINES = 480,
    parameter int P_WIN         = 5
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               in_valid,
    input  logic [P_PIXEL_W-1:0]               in_pixel,
    input  logic                               in_sof,
    output logic                               out_valid,
    output logic [P_PIXEL_W*P_WIN*P_WIN-1:0]   out_window,
    output logic [$clog2(P_LINE_LEN)-1:0]      out_col,
    output logic [$clog2(P_FRAME_LINES)-1:0]   out_row
);

    localparam int c_COL_W = $clog2(P_LINE_LEN);
    localparam int c_ROW_W = $clog2(P_FRAME_LINES);
    localparam int c_HALF  = P_WIN / 2;

    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(P_LINE_LEN - 1);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(P_FRAME_LINES - 1);
    localparam logic [c_COL_W-1:0] c_HALF_X   = c_COL_W'(c_HALF);
    localparam logic [c_ROW_W-1:0] c_HALF_Y   = c_ROW_W'(c_HALF);
`ifdef LINE_WINDOW_EDGE_MASK_EN
    localparam logic [c_COL_W-1:0] c_MIN_X    = c_COL_W'(c_HALF);
    localparam logic [c_ROW_W-1:0] c_MIN_Y    = c_ROW_W'(c_HALF);
`else
    localparam logic [c_COL_W-1:0] c_MIN_X    = c_COL_W'(P_WIN - 1);
    localparam logic [c_ROW_W-1:0] c_MIN_Y    = c_ROW_W'(P_WIN - 1);
`endif

    // Reject unsupported window geometries at elaboration.
    generate
        if ((P_WIN % 2 == 0) || (P_WIN < 3) || (P_WIN > 7) ||
            (P_LINE_LEN < P_WIN) || (P_FRAME_LINES < P_WIN)) begin : g_bad_param
            $error("line_window_buffer: unsupported P_WIN/P_LINE_LEN/P_FRAME_LINES");
        end
    endgenerate

    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_COL_W-1:0]   r_ptr;
    logic [c_COL_W-1:0]   w_x;
    logic [c_ROW_W-1:0]   w_y;
    logic                 w_qual;
    logic [P_PIXEL_W-1:0] r_mem [0:P_WIN-2][0:P_LINE_LEN-1];
    logic [P_PIXEL_W-1:0] w_col [0:P_WIN-1];
    logic [P_PIXEL_W-1:0] r_win [0:P_WIN-1][0:P_WIN-1];
`ifdef LINE_WINDOW_EDGE_MASK_EN
    logic [c_COL_W-1:0]   r_x;
    logic [c_ROW_W-1:0]   r_y;
`endif

    // Position of the pixel being offered; a start of frame forces (0,0).
    always_comb begin
        w_x    = in_sof ? '0 : r_col;
        w_y    = in_sof ? '0 : r_row;
        w_qual = (w_x >= c_MIN_X) && (w_y >= c_MIN_Y);
    end

    // New window column: bottom row is the incoming pixel, row r above it is
    // the pixel from (P_WIN-1-r) lines ago read out of the line memories.
    always_comb begin
        w_col[P_WIN-1] = in_pixel;
        for (int r = 0; r < P_WIN - 1; r++) begin
            w_col[r] = r_mem[P_WIN-2-r][r_ptr];
        end
    end

    // Line memories cascade: each one passes its one-line-old pixel upward.
    // They are never cleared; stale content is hidden by out_valid.
    always_ff @(posedge clk) begin
        if (reset_n && in_valid) begin
            r_mem[0][r_ptr] <= in_pixel;
            for (int k = 1; k < P_WIN - 1; k++) begin
                r_mem[k][r_ptr] <= r_mem[k-1][r_ptr];
            end
        end
    end

    // Counters, line pointer, window shift register and output qualifiers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_ptr     <= '0;
            out_valid <= 1'b0;
            out_col   <= '0;
            out_row   <= '0;
`ifdef LINE_WINDOW_EDGE_MASK_EN
            r_x       <= '0;
            r_y       <= '0;
`endif
            for (int r = 0; r < P_WIN; r++) begin
                for (int c = 0; c < P_WIN; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (in_valid) begin
            // The pointer free-runs so line memories always delay by exactly
            // one line of accepted pixels, independent of in_sof restarts.
            r_ptr <= (r_ptr == c_LAST_COL) ? '0 : r_ptr + 1'b1;
            if (w_x == c_LAST_COL) begin
                r_col <= '0;
                r_row <= (w_y == c_LAST_ROW) ? '0 : w_y + 1'b1;
            end else begin
                r_col <= w_x + 1'b1;
                r_row <= w_y;
            end
            for (int r = 0; r < P_WIN; r++) begin
                for (int c = 0; c < P_WIN - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][P_WIN-1] <= w_col[r];
            end
            out_valid <= w_qual;
            if (w_qual) begin
                out_col <= w_x - c_HALF_X;
                out_row <= w_y - c_HALF_Y;
            end
`ifdef LINE_WINDOW_EDGE_MASK_EN
            r_x <= w_x;
            r_y <= w_y;
`endif
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Pack the window taps; border mode zeroes taps above/left of the frame.
    always_comb begin
        out_window = '0;
        for (int r = 0; r < P_WIN; r++) begin
            for (int c = 0; c < P_WIN; c++) begin
`ifdef LINE_WINDOW_EDGE_MASK_EN
                if (((int'(r_y) + r) < (P_WIN - 1)) || ((int'(r_x) + c) < (P_WIN - 1))) begin
                    out_window[(P_WIN*P_WIN-1-(r*P_WIN+c))*P_PIXEL_W +: P_PIXEL_W] = '0;
                end else begin
                    out_window[(P_WIN*P_WIN-1-(r*P_WIN+c))*P_PIXEL_W +: P_PIXEL_W] = r_win[r][c];
                end
`else
                out_window[(P_WIN*P_WIN-1-(r*P_WIN+c))*P_PIXEL_W +: P_PIXEL_W] = r_win[r][c];
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_window_buffer
// Purpose  : Self-checking bench for line_window_buffer against a frame-image
//            reference model (P_PIXEL_W=8, P_LINE_LEN=8, P_FRAME_LINES=6,
//            P_WIN=3). Honours `LINE_WINDOW_EDGE_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_window_buffer;

    localparam int c_PW   = 8;
    localparam int c_LL   = 8;
    localparam int c_FL   = 6;
    localparam int c_WN   = 3;
    localparam int c_HALF = c_WN / 2;
    localparam int c_WW   = c_PW * c_WN * c_WN;
`ifdef LINE_WINDOW_EDGE_MASK_EN
    localparam int              c_QMIN      = c_HALF;
    localparam int              c_PULSES    = (c_LL - c_HALF) * (c_FL - c_HALF);
    localparam logic [c_WW-1:0] c_FIRST_WIN = 72'h00_00_00_00_00_01_00_10_11;
    localparam int              c_FIRST_CR  = 0;
`else
    localparam int              c_QMIN      = c_WN - 1;
    localparam int              c_PULSES    = (c_LL - c_WN + 1) * (c_FL - c_WN + 1);
    localparam logic [c_WW-1:0] c_FIRST_WIN = 72'h00_01_02_10_11_12_20_21_22;
    localparam int              c_FIRST_CR  = 1;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic [c_PW-1:0] in_pixel;
    logic            in_sof;
    logic            out_valid;
    logic [c_WW-1:0] out_window;
    logic [2:0]      out_col;
    logic [2:0]      out_row;

    line_window_buffer #(
        .P_PIXEL_W     (c_PW),
        .P_LINE_LEN    (c_LL),
        .P_FRAME_LINES (c_FL),
        .P_WIN         (c_WN)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_window (out_window),
        .out_col    (out_col),
        .out_row    (out_row)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: raster position and the image of the frame.
    int              mx = 0;
    int              my = 0;
    logic [c_PW-1:0] img [0:c_FL-1][0:c_LL-1];
    int              pulse_cnt = 0;
    bit              first_pending = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window centred at (x-HALF, y-HALF) read straight from the frame image.
    function automatic logic [c_WW-1:0] model_window(input int x, input int y);
        logic [c_WW-1:0] w;
        w = '0;
        for (int r = 0; r < c_WN; r++) begin
            for (int c = 0; c < c_WN; c++) begin
                int ty;
                int tx;
                ty = y - (c_WN - 1) + r;
                tx = x - (c_WN - 1) + c;
                if (ty >= 0 && tx >= 0)
                    w[(c_WN*c_WN-1-(r*c_WN+c))*c_PW +: c_PW] = img[ty][tx];
            end
        end
        return w;
    endfunction

    function automatic logic [c_PW-1:0] pix_rc(input int i);
        logic [3:0] rr;
        logic [3:0] cc;
        rr = 4'(i / c_LL);
        cc = 4'(i % c_LL);
        return {rr, cc};
    endfunction

    // One clock: drive, let the model react to an accept, compare 1 ns later.
    task automatic step(input bit v, input bit sof, input logic [c_PW-1:0] pix);
        bit              exp_v;
        int              x;
        int              y;
        int              exp_c;
        int              exp_r;
        logic [c_WW-1:0] exp_w;
        in_valid = v;
        in_sof   = sof;
        in_pixel = pix;
        @(posedge clk);
        exp_v = 0;
        exp_c = 0;
        exp_r = 0;
        exp_w = '0;
        if (v) begin
            x = sof ? 0 : mx;
            y = sof ? 0 : my;
            img[y][x] = pix;
            if (x >= c_QMIN && y >= c_QMIN) begin
                exp_v = 1;
                exp_c = x - c_HALF;
                exp_r = y - c_HALF;
                exp_w = model_window(x, y);
            end
            mx = (x + 1) % c_LL;
            if (mx == 0) my = (y + 1) % c_FL;
            else         my = y;
        end
        #1;
        check("out_valid", out_valid, exp_v);
        if (exp_v) begin
            check("out_window", out_window, exp_w);
            check("out_col", out_col, exp_c);
            check("out_row", out_row, exp_r);
        end
        if (out_valid === 1'b1) begin
            pulse_cnt++;
            if (first_pending) begin
                first_pending = 0;
                check("first_window", out_window, c_FIRST_WIN);
                check("first_col", out_col, c_FIRST_CR);
                check("first_row", out_row, c_FIRST_CR);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < c_FL; r++)
            for (int c = 0; c < c_LL; c++)
                img[r][c] = '0;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_pixel = 8'h00;

        // Reset held with live, toggling input.
        for (int i = 0; i < 3; i++) begin
            in_pixel = (i % 2 == 0) ? 8'hA5 : 8'h5A;
            in_sof   = (i == 1);
            @(posedge clk);
            #1;
            check("rst_valid", out_valid, 0);
            check("rst_window", out_window, 0);
            check("rst_col", out_col, 0);
            check("rst_row", out_row, 0);
        end
        reset_n = 1'b1;

        // Full frame, continuous valid.
        pulse_cnt = 0;
        first_pending = 1;
        for (int i = 0; i < c_LL * c_FL; i++) step(1, i == 0, pix_rc(i));
        check("pulses_full", pulse_cnt, c_PULSES);

        // Same frame with alternating idle cycles.
        pulse_cnt = 0;
        first_pending = 1;
        for (int i = 0; i < c_LL * c_FL; i++) begin
            step(1, i == 0, pix_rc(i));
            step(0, 0, 8'($urandom));
        end
        check("pulses_gapped", pulse_cnt, c_PULSES);

        // Random partial frame, then in_sof on the pixel at (3,3).
        for (int i = 0; i < 3 * c_LL + 3; i++) step(1, i == 0, 8'($urandom));
        pulse_cnt = 0;
        first_pending = 1;
        for (int i = 0; i < c_LL * c_FL; i++) step(1, i == 0, pix_rc(i));
        check("pulses_after_sof", pulse_cnt, c_PULSES);

        // Back-to-back frames; the second one relies on the implicit wrap.
        for (int i = 0; i < c_LL * c_FL; i++) step(1, i == 0, pix_rc(i));
        pulse_cnt = 0;
        first_pending = 1;
        for (int i = 0; i < c_LL * c_FL; i++) step(1, 0, pix_rc(i));
        check("pulses_wrap", pulse_cnt, c_PULSES);

        // Random data, random stalls and occasional stray start-of-frame.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
